i2c_reg_reader: RTL and testbench
=================================

Name: i2c_reg_reader

Overview:
Transaction sequencer directly upstream of i2c_master. Drives its ena/addr/rw/data_wr command interface to perform a register-pointer write followed by a repeated-start burst read of NUM_BYTES from one slave. Runs on a start pulse or periodically. Publishes the assembled bytes with a valid strobe to the display/datapath logic.

Parameters:
SLAVE_ADDR, 7'h68, 7-bit slave address used for every command
REG_ADDR, 8'h3B, register pointer written before the read burst
NUM_BYTES, 2, bytes read per transaction; legal range 1..4
PERIOD_CYCLES, 1_000_000, auto-mode launch interval in clk cycles (10 ms at 100 MHz)
TIMEOUT_CYCLES, 2_000_000, maximum cycles allowed in XFER before abort

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle launch request; ignored unless state is IDLE
auto_en  in  1  1 = launch every PERIOD_CYCLES
i2c_busy  in  1  busy from i2c_master
i2c_data_rd  in  8  data_rd from i2c_master
i2c_ack_error  in  1  ack_error from i2c_master
i2c_ena  out  1  ena to i2c_master
i2c_addr  out  7  addr to i2c_master
i2c_rw  out  1  rw to i2c_master; 0 = write, 1 = read
i2c_data_wr  out  8  data_wr to i2c_master
rd_data  out  32  last good result; first byte read is most significant; zero-extended above 8*NUM_BYTES
rd_valid  out  1  one-cycle pulse when rd_data updates
err  out  1  one-cycle pulse on NACK or timeout
active  out  1  high in any state other than IDLE

Behaviour:
- Reset: i2c_ena=0, i2c_addr=SLAVE_ADDR, i2c_rw=0, i2c_data_wr=REG_ADDR, rd_data=0, rd_valid=0, err=0, active=0. State IDLE; all counters 0; busy_q=0.
- busy_q registers i2c_busy. busy_rise = i2c_busy & ~busy_q. busy_fall = ~i2c_busy & busy_q.
- Period counter runs whenever auto_en=1; it wraps at PERIOD_CYCLES-1 and raises a one-cycle tick at the wrap. It clears while auto_en=0.
- IDLE: launch on (start | tick) only when i2c_busy=0; otherwise the request is dropped, not queued. On launch, enter XFER next cycle with: i2c_ena=1, i2c_rw=0, i2c_data_wr=REG_ADDR, rise_cnt=0, shift register=0, err_flag=0, timeout counter=0.
- XFER, on each busy_rise: rise_cnt increments.
  - New rise_cnt=1 (write latched): set i2c_rw=1. The next command is a repeated-start read.
  - New rise_cnt=k, with 3 <= k <= NUM_BYTES+1: shift i2c_data_rd into the shift register (shreg = {shreg[23:0], i2c_data_rd}). This captures the previous read byte.
  - New rise_cnt = NUM_BYTES+1: drop i2c_ena to 0 in the same registered update. This is the last command.
- XFER, while i2c_ena=0 and busy_fall: shift in the final i2c_data_rd and go to DONE.
- i2c_ack_error=1 on any XFER cycle sets err_flag. Sequencing continues; the master terminates the transfer.
- Timeout: when the timeout counter reaches TIMEOUT_CYCLES-1, force i2c_ena=0, set err_flag, and go to DRAIN.
- DRAIN: wait until i2c_busy=0, then go to DONE. No further data is captured.
- DONE (one cycle):
  - err_flag=0: rd_data <= shreg masked to 8*NUM_BYTES bits; rd_valid=1.
  - err_flag=1: err=1; rd_data unchanged.
  - Next state is IDLE.
- start and tick are ignored outside IDLE.
- If start and tick coincide, only one transaction launches.
- Reset asserted mid-transfer returns all outputs to reset values immediately. The i2c_master is reset by the same reset_n.
- Latency: rd_valid asserts exactly 2 cycles after the final busy_fall (fall sampled in XFER, then DONE registered).

Decomposition:
- Shared package: state encoding (IDLE, XFER, DRAIN, DONE) and MAX_BYTES=4.
- One sub-module is natural: i2c_tick_gen (period counter with enable and clear), reused for other sensor pollers.
- Sequencing and data capture stay in the top of this block.

Test Plan:
1. Behavioural master model (busy pulses of 9 bit times), slave returns 8'hAB, 8'hCD; pulse start → command sequence write 3B then read, read; rd_data=32'h0000ABCD; one rd_valid pulse.
2. NUM_BYTES=1, slave returns 8'h5A → i2c_ena drops on the 2nd busy rise; rd_data=32'h0000005A.
3. Model asserts ack_error on the write byte → err pulses once, rd_valid stays 0, rd_data keeps its previous value, active returns to 0.
4. Model holds busy high permanently → after TIMEOUT_CYCLES, i2c_ena=0 and state is DRAIN; release busy → err pulse, return to IDLE.
5. auto_en=1, PERIOD_CYCLES=1000 → a launch every 1000 cycles; a start pulse during XFER produces no extra transaction.
6. reset_n low in the middle of the read byte → i2c_ena=0 and active=0 immediately; after release, a start gives a clean full transaction.

Source files
------------

// File: rtl/i2c_reg_reader_pkg.sv
// Shared definitions for the i2c register reader: sequencer states and
// read-burst sizing helpers.
package i2c_reg_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_BYTES = 4;

  // Mask keeping the low 8*n bits of a 32-bit result.
  function automatic logic [31:0] byte_mask(input int n);
    if (n >= MAX_BYTES) byte_mask = 32'hFFFF_FFFF;
    else byte_mask = (32'd1 << (8 * n)) - 32'd1;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running period counter: one-cycle tick every PERIOD_CYCLES while
// enabled, held at zero while disabled.
module i2c_tick_gen #(
  parameter int PERIOD_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CW-1:0] count;

  assign tick = en && (count == CW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (!en || tick) count <= '0;
    else count <= count + CW'(1);
  end

endmodule

// File: rtl/i2c_reg_reader.sv
// Command sequencer for i2c_master: pointer write, repeated-start burst read
// of NUM_BYTES, result published with rd_valid or flagged with err.
module i2c_reg_reader
  import i2c_reg_reader_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR     = 7'h68,
  parameter logic [7:0] REG_ADDR       = 8'h3B,
  parameter int         NUM_BYTES      = 2,
  parameter int         PERIOD_CYCLES  = 1_000_000,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        auto_en,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_data_rd,
  input  logic        i2c_ack_error,
  output logic        i2c_ena,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_data_wr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        err,
  output logic        active,
  output logic [1:0]  state_dbg
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  LAST_RISE = 3'(NUM_BYTES + 1);
  localparam logic [31:0] RD_MASK   = byte_mask(NUM_BYTES);

  state_t        state, state_n;
  logic          busy_q, busy_rise, busy_fall, tick;
  logic          launch, timeout_hit, final_fall;
  logic [2:0]    rise_cnt, rise_nxt;
  logic [31:0]   shreg;
  logic          err_flag;
  logic [TW-1:0] to_cnt;

  i2c_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (auto_en),
    .tick    (tick)
  );

  assign busy_rise = i2c_busy & ~busy_q;
  assign busy_fall = ~i2c_busy & busy_q;
  assign rise_nxt  = rise_cnt + 3'd1;
  assign i2c_addr  = SLAVE_ADDR;
  assign active    = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n     = state;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    final_fall  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A request arriving while the master is busy is dropped, not queued.
        if ((start || tick) && !i2c_busy) begin
          launch  = 1'b1;
          state_n = ST_XFER;
        end
      end
      ST_XFER: begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_n     = ST_DRAIN;
        end else if (!i2c_ena && busy_fall) begin
          final_fall = 1'b1;
          state_n    = ST_DONE;
        end
      end
      ST_DRAIN: if (!i2c_busy) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      i2c_ena     <= 1'b0;
      i2c_rw      <= 1'b0;
      i2c_data_wr <= REG_ADDR;
      rise_cnt    <= '0;
      shreg       <= '0;
      err_flag    <= 1'b0;
      to_cnt      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      err         <= 1'b0;
    end else begin
      busy_q   <= i2c_busy;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            i2c_ena     <= 1'b1;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= REG_ADDR;
            rise_cnt    <= '0;
            shreg       <= '0;
            err_flag    <= 1'b0;
            to_cnt      <= '0;
          end
        end
        ST_XFER: begin
          to_cnt <= to_cnt + TW'(1);
          if (i2c_ack_error) err_flag <= 1'b1;
          if (timeout_hit) begin
            i2c_ena  <= 1'b0;
            err_flag <= 1'b1;
          end else if (busy_rise) begin
            // Each rise means the master latched the next command, so
            // data_rd now holds the byte from the previous read command.
            rise_cnt <= rise_nxt;
            if (rise_nxt == 3'd1) i2c_rw <= 1'b1;
            if (rise_nxt >= 3'd3 && rise_nxt <= LAST_RISE)
              shreg <= {shreg[23:0], i2c_data_rd};
            if (rise_nxt == LAST_RISE) i2c_ena <= 1'b0;
          end else if (final_fall) begin
            shreg <= {shreg[23:0], i2c_data_rd};
          end
        end
        ST_DONE: begin
          if (err_flag) begin
            err <= 1'b1;
          end else begin
            rd_data  <= shreg & RD_MASK;
            rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Bench for i2c_reg_reader: behavioural i2c_master/slave model driving two
// instances (2-byte and 1-byte bursts), scoreboard of expected results.
module tb_i2c_reg_reader;
  import i2c_reg_reader_pkg::*;

  localparam int P   = 1000;
  localparam int T   = 400;
  localparam int BIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  start_v, auto_v, busy_v, ack_v, ena_v, rw_v, rdv_v, err_v, act_v;
  logic [7:0]  drd_v [2];
  logic [7:0]  dwr_v [2];
  logic [6:0]  addr_v [2];
  logic [31:0] rdd_v [2];
  logic [1:0]  st_v [2];

  i2c_reg_reader #(.NUM_BYTES(2), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .auto_en(auto_v[0]),
    .i2c_busy(busy_v[0]), .i2c_data_rd(drd_v[0]), .i2c_ack_error(ack_v[0]),
    .i2c_ena(ena_v[0]), .i2c_addr(addr_v[0]), .i2c_rw(rw_v[0]),
    .i2c_data_wr(dwr_v[0]), .rd_data(rdd_v[0]), .rd_valid(rdv_v[0]),
    .err(err_v[0]), .active(act_v[0]), .state_dbg(st_v[0]));

  i2c_reg_reader #(.NUM_BYTES(1), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .auto_en(auto_v[1]),
    .i2c_busy(busy_v[1]), .i2c_data_rd(drd_v[1]), .i2c_ack_error(ack_v[1]),
    .i2c_ena(ena_v[1]), .i2c_addr(addr_v[1]), .i2c_rw(rw_v[1]),
    .i2c_data_wr(dwr_v[1]), .rd_data(rdd_v[1]), .rd_valid(rdv_v[1]),
    .err(err_v[1]), .active(act_v[1]), .state_dbg(st_v[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0, n_fail = 0;
  int vcnt [2], ecnt [2], lcnt [2], last_fall [2], act_rise [2];
  logic        act_prev [2];
  logic [31:0] last_exp [2];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [7:0]  dir_q[$];
  bit          hold, nack_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nb_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Master/slave model: each command keeps busy high for 9 bit times, then
  // drops it for at least one cycle; read bytes come from dir_q or random.
  bit          m_run [2];
  bit          m_rw [2];
  int          m_cnt [2], n_cmd [2], tr_n [2];
  logic [7:0]  tr_b [2][8];

  initial begin
    busy_v = '0; ack_v = '0; drd_v[0] = '0; drd_v[1] = '0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; n_cmd[i] = 0; tr_n[i] = 0; m_cnt[i] = 0; m_rw[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        ack_v[i] = 1'b0;
        if (!reset_n) begin
          busy_v[i] = 1'b0; m_run[i] = 0; n_cmd[i] = 0; tr_n[i] = 0;
        end else if (hold && i == 0) begin
          busy_v[i] = 1'b1; m_run[i] = 0; n_cmd[i] = 0; tr_n[i] = 0;
        end else if (!m_run[i]) begin
          busy_v[i] = 1'b0;
          if (ena_v[i]) begin
            check("cmd_addr", 32'(addr_v[i]), 32'h68);
            if (n_cmd[i] == 0) begin
              check("cmd0_rw", 32'(rw_v[i]), 32'd0);
              check("cmd0_data_wr", 32'(dwr_v[i]), 32'h3B);
            end else begin
              check("cmdn_rw", 32'(rw_v[i]), 32'd1);
            end
            m_rw[i] = rw_v[i]; n_cmd[i]++; m_cnt[i] = 9 * BIT;
            m_run[i] = 1; busy_v[i] = 1'b1;
          end
        end else begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            busy_v[i] = 1'b0; m_run[i] = 0;
            if (m_rw[i]) begin
              logic [7:0] b;
              if (dir_q.size() > 0) b = dir_q.pop_front();
              else b = 8'($urandom_range(0, 255));
              drd_v[i] = b;
              if (tr_n[i] < 8) tr_b[i][tr_n[i]] = b;
              tr_n[i]++;
            end else if (nack_req) begin
              ack_v[i] = 1'b1;
            end
            if (!ena_v[i]) begin
              logic [31:0] e;
              check("cmd_count", 32'(n_cmd[i]), 32'(nb_of(i) + 1));
              last_fall[i] = cyc;
              e = '0;
              for (int j = 0; j < nb_of(i); j++) e = (e << 8) | 32'(tr_b[i][j]);
              if (!nack_req) begin
                if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
                last_exp[i] = e;
              end
              n_cmd[i] = 0; tr_n[i] = 0;
            end
          end
        end
      end
    end
  end

  // Monitor: result scoreboard, rd_valid latency, pulse and launch counts.
  initial begin
    for (int i = 0; i < 2; i++) begin
      vcnt[i] = 0; ecnt[i] = 0; lcnt[i] = 0; act_prev[i] = 0;
      last_fall[i] = 0; act_rise[i] = 0; last_exp[i] = '0;
    end
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++) begin
        if (rdv_v[i]) begin
          logic [31:0] e;
          int qs;
          vcnt[i]++;
          check("rd_valid_latency", 32'(cyc - last_fall[i]), 32'd2);
          qs = (i == 0) ? exp_q0.size() : exp_q1.size();
          if (qs == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
          else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("rd_data", rdd_v[i], e);
          end
        end
        if (err_v[i]) ecnt[i]++;
        if (act_v[i] && !act_prev[i]) begin
          lcnt[i]++; act_rise[i] = cyc;
        end
        act_prev[i] = act_v[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1; tick(1); start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int v0, k;
    v0 = vcnt[i] + ecnt[i]; k = 0;
    while (vcnt[i] + ecnt[i] == v0 && k < budget) begin tick(1); k++; end
    if (k >= budget) check(tag, 32'(vcnt[i] + ecnt[i] - v0), 32'd1);
  endtask

  initial begin
    int v0, e0, l0, k;
    reset_n = 1'b0; start_v = '0; auto_v = '0; hold = 0; nack_req = 0;
    tick(3);
    check("rst_ena", 32'(ena_v[0]), 32'd0);
    check("rst_addr", 32'(addr_v[0]), 32'h68);
    check("rst_rw", 32'(rw_v[0]), 32'd0);
    check("rst_data_wr", 32'(dwr_v[0]), 32'h3B);
    check("rst_rd_data", rdd_v[0], 32'd0);
    check("rst_rd_valid", 32'(rdv_v[0]), 32'd0);
    check("rst_err", 32'(err_v[0]), 32'd0);
    check("rst_active", 32'(act_v[0]), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Directed AB/CD burst, then random bursts.
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin dir_q.push_back(8'hAB); dir_q.push_back(8'hCD); end
      v0 = vcnt[0]; e0 = ecnt[0];
      pulse_start(0);
      wait_done(0, 500, "wait_read");
      tick(3);
      if (t == 0) check("rd_data_abcd", rdd_v[0], 32'h0000ABCD);
      check("read_valid_once", 32'(vcnt[0] - v0), 32'd1);
      check("read_no_err", 32'(ecnt[0] - e0), 32'd0);
      check("read_idle", 32'(act_v[0]), 32'd0);
    end

    // Single-byte burst: ena must drop on the 2nd rise (cmd_count = 2).
    dir_q.push_back(8'h5A);
    v0 = vcnt[1];
    pulse_start(1);
    wait_done(1, 500, "wait_read1");
    tick(3);
    check("rd_data_5a", rdd_v[1], 32'h0000005A);
    check("read1_valid_once", 32'(vcnt[1] - v0), 32'd1);

    // NACK on the pointer write.
    v0 = vcnt[0]; e0 = ecnt[0];
    nack_req = 1;
    pulse_start(0);
    wait_done(0, 500, "wait_nack");
    nack_req = 0;
    tick(3);
    check("nack_err_once", 32'(ecnt[0] - e0), 32'd1);
    check("nack_no_valid", 32'(vcnt[0] - v0), 32'd0);
    check("nack_rd_kept", rdd_v[0], last_exp[0]);
    check("nack_idle", 32'(act_v[0]), 32'd0);

    // Timeout with busy stuck high.
    v0 = vcnt[0]; e0 = ecnt[0];
    pulse_start(0);
    k = 0;
    while (!busy_v[0] && k < 50) begin tick(1); k++; end
    hold = 1;
    k = 0;
    while (st_v[0] !== 2'(ST_DRAIN) && k < T + 100) begin tick(1); k++; end
    check("to_state_drain", 32'(st_v[0]), 32'(ST_DRAIN));
    check("to_cycles", 32'(cyc - act_rise[0]), 32'(T));
    check("to_ena_low", 32'(ena_v[0]), 32'd0);
    tick(20);
    check("to_still_drain", 32'(st_v[0]), 32'(ST_DRAIN));
    hold = 0;
    wait_done(0, 50, "wait_drain");
    tick(3);
    check("to_err_once", 32'(ecnt[0] - e0), 32'd1);
    check("to_no_valid", 32'(vcnt[0] - v0), 32'd0);
    check("to_idle", 32'(act_v[0]), 32'd0);
    check("to_rd_kept", rdd_v[0], last_exp[0]);

    // Auto mode: one launch per period; a start mid-transfer adds nothing.
    v0 = vcnt[0]; l0 = lcnt[0];
    auto_v[0] = 1'b1;
    for (int c = 0; c < 3 * P + 200; c++) begin
      if (c == P + 20) start_v[0] = 1'b1;
      if (c == P + 21) start_v[0] = 1'b0;
      tick(1);
    end
    auto_v[0] = 1'b0;
    tick(200);
    check("auto_launches", 32'(lcnt[0] - l0), 32'((3 * P + 200) / P));
    check("auto_valids", 32'(vcnt[0] - v0), 32'((3 * P + 200) / P));

    // Reset in the middle of the first read byte.
    pulse_start(0);
    k = 0;
    while (n_cmd[0] != 2 && k < 300) begin tick(1); k++; end
    check("rst_mid_reached_read", 32'(n_cmd[0]), 32'd2);
    tick(10);
    @(negedge clk); reset_n = 1'b0; #1;
    check("rst_mid_ena", 32'(ena_v[0]), 32'd0);
    check("rst_mid_active", 32'(act_v[0]), 32'd0);
    check("rst_mid_rd_data", rdd_v[0], 32'd0);
    exp_q0.delete(); last_exp[0] = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    v0 = vcnt[0];
    pulse_start(0);
    wait_done(0, 500, "wait_after_rst");
    tick(3);
    check("after_rst_valid", 32'(vcnt[0] - v0), 32'd1);
    check("after_rst_idle", 32'(act_v[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
